csr_packer: RTL and testbench
=============================

# csr_packer

Streaming encoder that converts a dense feature/adjacency matrix, delivered one element per handshake in row-major order, into the compressed-row frame consumed by the row scheduler. The frame carries flattened `col_idx`, `value` and `node_info` vectors. The block sits upstream of the scheduler. It buffers one complete frame, presents it with a valid/ready handshake, then accepts the next matrix.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: element width.
- `NUM_OF_COLS`, default 5: matrix columns.
- `NUM_OF_ROWS`, default 5: matrix rows. Also the number of `node_info` entries.
- `COL_INDEX_SIZE`, default 8: nonzero capacity per frame. This is also the number of value slots.
- Derived widths:
  - `COL_IDX_WIDTH = $clog2(NUM_OF_COLS)`
  - `INDEX_WIDTH = $clog2(COL_INDEX_SIZE)`
  - `ROW_LEN_WIDTH = $clog2(NUM_OF_COLS+1)`
  - `NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1`
  - `NNZ_WIDTH = $clog2(COL_INDEX_SIZE+1)`

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid_i`, input, 1: dense element valid.
- `in_data_i`, input, `DATA_WIDTH`: dense element, row-major.
- `in_ready_o`, output, 1: element accepted when `in_valid_i && in_ready_o`.
- `csr_valid_o`, output, 1: frame outputs valid.
- `csr_ready_i`, input, 1: consumer takes frame when `csr_valid_o && csr_ready_i`.
- `col_idx_o`, output, `COL_IDX_WIDTH*COL_INDEX_SIZE`: slot 0 in the MSB slice, slot k at bits `[(COL_INDEX_SIZE-k)*COL_IDX_WIDTH-1 -: COL_IDX_WIDTH]`.
- `value_o`, output, `DATA_WIDTH*COL_INDEX_SIZE`: same ordering as `col_idx_o`, slot 0 in the MSB slice.
- `node_info_o`, output, `NODE_INFO_WIDTH*NUM_OF_ROWS`: row 0 in the MSB slice. Each entry is `{start_idx[INDEX_WIDTH], row_len[ROW_LEN_WIDTH], flag}`, MSB to LSB.
- `nnz_o`, output, `NNZ_WIDTH`: count of stored nonzeros.
- `overflow_o`, output, 1: the frame contained more than `COL_INDEX_SIZE` nonzeros.

## Operation

**State machine.** Two states, `COLLECT` and `HOLD`. Reset enters `COLLECT`.

**COLLECT**
- `in_ready_o` = 1 and `csr_valid_o` = 0.
- Registers:
  - Column counter `c` and row counter `r`.
  - Write pointer `wp`, width `NNZ_WIDTH`.
  - Current-row length `len`.
  - Row start pointer `rs`.
- On each accepted element where `in_data_i != 0`:
  - If `wp < COL_INDEX_SIZE`: write slot `wp` with `col_idx = c` and `value = in_data_i`, then increment `wp` and `len`.
  - Otherwise: drop the element and set `overflow_o`. The flag is sticky until the frame is consumed.
- Zero elements are never stored.
- On acceptance with `c == NUM_OF_COLS-1` (end of row):
  - Write `node_info[r] = {rs[INDEX_WIDTH-1:0], len_final, r == NUM_OF_ROWS-1}`. `len_final` includes the current element if it was stored.
  - Set `rs` = the new `wp`, clear `len` and `c`, and increment `r`.
- Otherwise `c` increments.
- Accepting the element at `r == NUM_OF_ROWS-1`, `c == NUM_OF_COLS-1` moves the FSM to `HOLD`.

**HOLD**
- `csr_valid_o` = 1 and `in_ready_o` = 0. `in_valid_i` is ignored.
- All frame outputs are held stable.
- On `csr_ready_i`: move to `COLLECT`. At that point:
  - Clear all slots, `node_info`, `wp`, `r`, `c`, `len`, `rs` and `overflow_o` to 0.
  - `nnz_o` becomes 0.

**Field rules**
- `flag` = 1 only on the last row.
- `row_len` counts stored entries only and reaches at most `NUM_OF_COLS`.
- `start_idx` is `rs` truncated to `INDEX_WIDTH` bits. It wraps to 0 when `rs == COL_INDEX_SIZE` (a power of two). Those rows always have `row_len = 0`.
- Unused slots read 0.
- `nnz_o` = `wp`, and saturates at `COL_INDEX_SIZE`.

## Timing

- All outputs are registered.
- Reset values: `in_ready_o` = 1, `csr_valid_o` = 0, `col_idx_o` / `value_o` / `node_info_o` = 0, `nnz_o` = 0, `overflow_o` = 0.
- Throughput: one element per cycle while `in_valid_i` is held.
- Stalls: a cycle with `in_valid_i` = 0 changes nothing.
- Output latency: `csr_valid_o` rises the cycle after the final element is accepted. Frame contents are complete in that same cycle.
- Frame release: with the handshake in cycle t, `in_ready_o` = 1 and outputs are cleared in t+1. The earliest next element is accepted at t+1.
- Back-to-back frame period: `NUM_OF_ROWS*NUM_OF_COLS + 1` cycles when `csr_ready_i` is tied to 1.
- Reset asserted mid-frame: the partial frame is discarded and all reset values are restored on the next edge.

## Test plan

Defaults for all scenarios: 5x5 matrix, `COL_INDEX_SIZE` = 8, `DATA_WIDTH` = 8, so `NODE_INFO_WIDTH` = 7. `csr_ready_i` = 1 unless stated.

1. **Diagonal frame.** Stream a diagonal matrix with values 1..5. Required response:
   - `col_idx` slots = 0,1,2,3,4,0,0,0; `value` slots = 1,2,3,4,5,0,0,0.
   - `node_info[r]` = `{r,1,0}` for r = 0..3, and `node_info[4]` = 7'b1000011.
   - `nnz_o` = 5, `overflow_o` = 0, and `csr_valid_o` rises in cycle 26.
2. **All-zero frame.** Stream an all-zero matrix. Required response: `nnz_o` = 0, every slot 0, `node_info[0..3]` = 0, `node_info[4]` = 7'b0000001.
3. **Full rows and overflow.** Row 0 all 1s, row 1 all 2s, rest 0. Required response:
   - `node_info[0]` = `{0,5,0}`, `node_info[1]` = `{5,3,0}`.
   - `node_info[2]` = `{0,0,0}` (start index wrapped).
   - `value` slots = 1,1,1,1,1,2,2,2.
   - `nnz_o` = 8, `overflow_o` = 1.
4. **Backpressure.** Randomly gap `in_valid_i`, then hold `csr_ready_i` = 0 for 10 cycles after `csr_valid_o` rises. Required response:
   - Frame matches scenario 1 and outputs stay constant while held.
   - `in_ready_o` = 0 and extra `in_valid_i` is ignored.
   - On release, the next cycle has `in_ready_o` = 1 and all outputs 0.
5. **Reset mid-frame.** Assert `rst_n` = 0 after 7 elements. Required response: the next cycle shows reset values. A fresh scenario-1 stream then yields exactly the scenario-1 frame.

Source files
------------

// File: rtl/csr_packer.sv
`default_nettype none
// csr_packer: encodes a row-major dense matrix stream into one buffered compressed-row frame.
// Revision 1.0

module csr_packer #(
    parameter  int DATA_WIDTH      = 8,
    parameter  int NUM_OF_COLS     = 5,
    parameter  int NUM_OF_ROWS     = 5,
    parameter  int COL_INDEX_SIZE  = 8,
    localparam int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS),
    localparam int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE),
    localparam int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS + 1),
    localparam int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1,
    localparam int NNZ_WIDTH       = $clog2(COL_INDEX_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid_i,
    input  logic [DATA_WIDTH-1:0]                  in_data_i,
    output logic                                   in_ready_o,
    output logic                                   csr_valid_o,
    input  logic                                   csr_ready_i,
    output logic [COL_IDX_WIDTH*COL_INDEX_SIZE-1:0] col_idx_o,
    output logic [DATA_WIDTH*COL_INDEX_SIZE-1:0]    value_o,
    output logic [NODE_INFO_WIDTH*NUM_OF_ROWS-1:0]  node_info_o,
    output logic [NNZ_WIDTH-1:0]                    nnz_o,
    output logic                                    overflow_o
);

    localparam int ROW_CNT_WIDTH = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS + 1) : 1;

    localparam logic [COL_IDX_WIDTH-1:0] LAST_COL = COL_IDX_WIDTH'(NUM_OF_COLS - 1);
    localparam logic [ROW_CNT_WIDTH-1:0] LAST_ROW = ROW_CNT_WIDTH'(NUM_OF_ROWS - 1);
    localparam logic [NNZ_WIDTH-1:0]     CAPACITY = NNZ_WIDTH'(COL_INDEX_SIZE);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_IDX_WIDTH-1:0]   col_cnt;
    logic [ROW_CNT_WIDTH-1:0]   row_cnt;
    logic [NNZ_WIDTH-1:0]       wr_ptr;
    logic [ROW_LEN_WIDTH-1:0]   row_len;
    logic [INDEX_WIDTH-1:0]     row_start;
    logic                       overflow;

    logic [COL_IDX_WIDTH-1:0]   col_idx_q   [COL_INDEX_SIZE];
    logic [DATA_WIDTH-1:0]      value_q     [COL_INDEX_SIZE];
    logic [NODE_INFO_WIDTH-1:0] node_info_q [NUM_OF_ROWS];

    logic                       accept;
    logic                       nonzero;
    logic                       has_room;
    logic                       store;
    logic                       drop;
    logic                       end_row;
    logic                       frame_taken;
    logic [NNZ_WIDTH-1:0]       wr_ptr_next;
    logic [ROW_LEN_WIDTH-1:0]   row_len_final;

    assign accept        = in_valid_i && (state == COLLECT);
    assign nonzero       = |in_data_i;
    assign has_room      = (wr_ptr < CAPACITY);
    assign store         = accept && nonzero && has_room;
    assign drop          = accept && nonzero && !has_room;
    assign end_row       = accept && (col_cnt == LAST_COL);
    assign frame_taken   = (state == HOLD) && csr_ready_i;
    assign wr_ptr_next   = wr_ptr + NNZ_WIDTH'(store);
    assign row_len_final = row_len + ROW_LEN_WIDTH'(store);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        csr_valid_o = 1'b0;
        case (state)
            COLLECT: begin
                in_ready_o = 1'b1;
                if (in_valid_i && (col_cnt == LAST_COL) && (row_cnt == LAST_ROW)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                csr_valid_o = 1'b1;
                if (csr_ready_i) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Counters and pointers; a consumed frame clears exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_taken) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            wr_ptr    <= '0;
            row_len   <= '0;
            row_start <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (end_row) begin
                // Truncation wraps the start index when the slots are exactly full.
                row_start <= wr_ptr_next[INDEX_WIDTH-1:0];
                row_len   <= '0;
                col_cnt   <= '0;
                row_cnt   <= row_cnt + ROW_CNT_WIDTH'(1);
            end else begin
                row_len   <= row_len_final;
                col_cnt   <= col_cnt + COL_IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || frame_taken) begin
            for (int k = 0; k < COL_INDEX_SIZE; k++) begin
                col_idx_q[k] <= '0;
                value_q[k]   <= '0;
            end
        end else if (store) begin
            for (int k = 0; k < COL_INDEX_SIZE; k++) begin
                if (wr_ptr == NNZ_WIDTH'(k)) begin
                    col_idx_q[k] <= col_cnt;
                    value_q[k]   <= in_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || frame_taken) begin
            for (int i = 0; i < NUM_OF_ROWS; i++) begin
                node_info_q[i] <= '0;
            end
        end else if (end_row) begin
            for (int i = 0; i < NUM_OF_ROWS; i++) begin
                if (row_cnt == ROW_CNT_WIDTH'(i)) begin
                    node_info_q[i] <= {row_start, row_len_final, (row_cnt == LAST_ROW)};
                end
            end
        end
    end

    // Slot 0 / row 0 occupy the most-significant slice of each flattened vector.
    for (genvar k = 0; k < COL_INDEX_SIZE; k++) begin : g_slot
        assign col_idx_o[(COL_INDEX_SIZE-k)*COL_IDX_WIDTH-1 -: COL_IDX_WIDTH] = col_idx_q[k];
        assign value_o[(COL_INDEX_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]         = value_q[k];
    end

    for (genvar i = 0; i < NUM_OF_ROWS; i++) begin : g_row
        assign node_info_o[(NUM_OF_ROWS-i)*NODE_INFO_WIDTH-1 -: NODE_INFO_WIDTH] = node_info_q[i];
    end

    assign nnz_o      = wr_ptr;
    assign overflow_o = overflow;

endmodule

`default_nettype wire

// File: tb/tb_csr_packer.sv
`default_nettype none
// tb_csr_packer: directed checks of the csr_packer frame encoder at default 5x5 / 8-slot sizing.
// Revision 1.0

module tb_csr_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        csr_valid;
    logic        csr_ready;
    logic [23:0] col_idx;
    logic [63:0] value;
    logic [34:0] node_info;
    logic [3:0]  nnz;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] DIAG_COL = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
    localparam logic [63:0] DIAG_VAL = 64'h01020304_05000000;
    localparam logic [34:0] DIAG_NI  = {7'h02, 7'h12, 7'h22, 7'h32, 7'h43};
    localparam logic [34:0] ZERO_NI  = {7'h00, 7'h00, 7'h00, 7'h00, 7'h01};
    localparam logic [23:0] ROWS_COL = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    localparam logic [63:0] ROWS_VAL = 64'h01010101_01020202;
    localparam logic [34:0] ROWS_NI  = {7'h0A, 7'h56, 7'h00, 7'h00, 7'h01};

    csr_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .csr_valid_o (csr_valid),
        .csr_ready_i (csr_ready),
        .col_idx_o   (col_idx),
        .value_o     (value),
        .node_info_o (node_info),
        .nnz_o       (nnz),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] c, input logic [63:0] v,
                               input logic [34:0] ni, input logic [3:0] n, input logic ov);
        check({tag, "_col_idx"},   64'(col_idx),   64'(c));
        check({tag, "_value"},     value,          v);
        check({tag, "_node_info"}, 64'(node_info), 64'(ni));
        check({tag, "_nnz"},       64'(nnz),       64'(n));
        check({tag, "_overflow"},  64'(overflow),  64'(ov));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_csr_valid"}, 64'(csr_valid), 64'd0);
        check_frame(tag, 24'd0, 64'd0, 35'd0, 4'd0, 1'b0);
    endtask

    // kind 0: diagonal 1..5, kind 1: all zero, kind 2: row0 = 1s, row1 = 2s
    function automatic logic [7:0] elem(input int kind, input int i);
        case (kind)
            0:       return (i % 6 == 0) ? 8'(i / 6 + 1) : 8'd0;
            2:       return (i / 5 == 0) ? 8'd1 : ((i / 5 == 1) ? 8'd2 : 8'd0);
            default: return 8'd0;
        endcase
    endfunction

    task automatic stream(input int kind, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = elem(kind, i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'd0;
            if (i == 23) check("valid_before_last", 64'(csr_valid), 64'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        csr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        // Diagonal frame; valid rises the cycle after the 25th acceptance.
        stream(0, 1'b0, 25);
        check("diag_valid_rise", 64'(csr_valid), 64'd1);
        check("diag_in_ready", 64'(in_ready), 64'd0);
        check_frame("diag", DIAG_COL, DIAG_VAL, DIAG_NI, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        check_cleared("diag_release");

        // All-zero frame: only the last-row flag is set.
        stream(1, 1'b0, 25);
        check("zero_valid", 64'(csr_valid), 64'd1);
        check_frame("zero", 24'd0, 64'd0, ZERO_NI, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check_cleared("zero_release");

        // Full rows with overflow and a wrapped start index.
        stream(2, 1'b0, 25);
        check("ovf_valid", 64'(csr_valid), 64'd1);
        check_frame("ovf", ROWS_COL, ROWS_VAL, ROWS_NI, 4'd8, 1'b1);
        @(posedge clk);
        #1;
        check_cleared("ovf_release");

        // Gapped input, then the consumer stalls for 10 cycles.
        csr_ready = 1'b0;
        stream(0, 1'b1, 25);
        check("bp_valid_rise", 64'(csr_valid), 64'd1);
        check_frame("bp", DIAG_COL, DIAG_VAL, DIAG_NI, 4'd5, 1'b0);
        for (int h = 0; h < 10; h++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            @(posedge clk);
            #1;
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_valid", 64'(csr_valid), 64'd1);
            check_frame("bp_hold", DIAG_COL, DIAG_VAL, DIAG_NI, 4'd5, 1'b0);
        end
        in_valid  = 1'b0;
        in_data   = 8'd0;
        csr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("bp_release");

        // Reset after 7 elements discards the partial frame.
        stream(0, 1'b0, 7);
        check("mid_nnz_before_reset", 64'(nnz), 64'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("mid_reset");
        rst_n = 1'b1;
        stream(0, 1'b0, 25);
        check("post_reset_valid", 64'(csr_valid), 64'd1);
        check_frame("post_reset", DIAG_COL, DIAG_VAL, DIAG_NI, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        check_cleared("post_reset_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
